shift_unit_iter: RTL and testbench
==================================

// Module: shift_unit_iter
// PURPOSE
//  Parametrised, multi-cycle successor to the 8-bit shift unit in the multi-cycle datapath.
//  - Shifts or rotates a WIDTH-bit operand by a runtime amount, STEP bit positions per clock.
//  - Uses a start/busy/done handshake, so the controller FSM waits on done instead of a fixed latency.
//  - Holds the result on out until the next operation completes.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; >=2, power of two
//  STEP   1  max bit positions shifted per cycle; 1..WIDTH-1
//  AW     $clog2(WIDTH)  shift-amount width (localparam, derived)
// PORTS
//  clk    in   1      clock, all state updates on rising edge
//  rst    in   1      reset, asynchronous, active-high
//  start  in   1      request; sampled on rising clk in IDLE or DONE
//  in     in   WIDTH  operand, captured when start is accepted
//  op     in   3      000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101/110/111 pass
//  amt    in   AW     shift amount 0..WIDTH-1, captured with in
//  busy   out  1      high while in SHIFT
//  done   out  1      single-cycle completion pulse (state DONE)
//  out    out  WIDTH  result register
//  carry  out  1      last bit shifted/rotated out (present only with SHIFT_CARRY_EN)
// BEHAVIOUR
//  - Reset (any time, including mid-shift):
//    - state=IDLE, busy=0, done=0, out=0, carry=0.
//    - All internal work/remaining registers are cleared.
//  - FSM states are IDLE, SHIFT and DONE.
//    - IDLE/DONE, start=1 at edge E0: latch in->work, op, amt->rem.
//      - If amt==0 or op is pass, next state is DONE.
//      - Otherwise next state is SHIFT.
//    - IDLE/DONE, start=0: go to (or remain in) IDLE.
//    - SHIFT: on each edge, shift work by s=min(STEP,rem) and set rem-=s.
//      - When rem<=STEP, this is the final step: next state is DONE.
//      - On the final step, out and carry load the final result.
//    - DONE: lasts exactly one cycle, then the FSM behaves as IDLE (start accepted).
//  - Latency:
//    - n = ceil(amt/STEP), with n=0 for amt==0 or pass.
//    - done is high during the cycle after edge E0+n.
//    - Back-to-back: start held high in DONE begins the next operation with no idle cycle.
//  - Handshake and busy rules:
//    - start during SHIFT is ignored; no queuing, no effect on the current result.
//    - busy=1 exactly during SHIFT; busy and done are never high together.
//  - Output hold: out is unchanged during SHIFT and changes only on entry to DONE.
//  - Shift and rotate semantics:
//    - LSL/LSR: zero fill.
//    - ASR: replicates work[WIDTH-1] of the captured operand.
//    - ROL/ROR: wrap modulo WIDTH.
//  - Zero-amount path: amt==0 gives out=in.
//  - Arithmetic:
//    - amt is unsigned; the full range 0..WIDTH-1 is legal, so no overflow case exists.
//    - rem is AW bits wide and never underflows because s<=rem.
// CONFIGURATION
//  SHIFT_CARRY_EN defined:
//    - carry port exists.
//    - On the final step, carry = last bit shifted out (LSL: bit WIDTH-amt of in; LSR/ASR: bit amt-1).
//    - For rotates, carry = last bit that wrapped.
//    - For amt==0 or pass, carry=0.
//    - carry holds with out until the next completion.
//  SHIFT_CARRY_EN undefined:
//    - No carry port and no carry logic.
//    - All other behaviour is identical.
// TESTING (WIDTH=8 unless noted; E0 = start edge)
//  1. Reset: rst=1 asserted mid-SHIFT -> busy=0, done=0, out=8'h00 immediately, without waiting for clk.
//     Then rst=0, start with LSR in=8'h80 amt=1 -> out=8'h40.
//  2. STEP=1, LSL in=8'b1001_0110 amt=3:
//     - busy for 3 cycles; done after E0+3.
//     - out=8'b1011_0000, carry=0.
//  3. STEP=1, ASR in=8'b1001_0110 amt=2 -> done after E0+2, out=8'b1110_0101, carry=1.
//  4. STEP=4, ROR in=8'hA5 amt=4 -> one SHIFT cycle, done after E0+1, out=8'h5A.
//     Same config, ROL in=8'h81 amt=7 -> two SHIFT cycles, out=8'hC0.
//  5. amt=0, op=LSL, in=8'h3C -> busy never high, done after E0, out=8'h3C, carry=0.
//     op=110, in=8'hF0, amt=5 -> done after E0, out=8'hF0.
//  6. Handshake:
//     - start pulsed mid-SHIFT with a different in -> ignored; first result unchanged.
//     - start held in DONE with LSR in=8'hFF amt=1 -> accepted with no idle cycle, out=8'h7F.

Source files
------------

// File: rtl/shift_unit_iter_if.sv
// Start/busy/done handshake bundle for shift_unit_iter.
// The carry signal exists only when SHIFT_CARRY_EN is defined.
interface shift_unit_iter_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned AW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] in;
    logic [2:0]       op;
    logic [AW-1:0]    amt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
`ifdef SHIFT_CARRY_EN
    logic             carry;

    modport master (output start, in, op, amt, input busy, done, out, carry);
    modport slave  (input start, in, op, amt, output busy, done, out, carry);
`else
    modport master (output start, in, op, amt, input busy, done, out);
    modport slave  (input start, in, op, amt, output busy, done, out);
`endif
endinterface

// File: rtl/shift_unit_iter.sv
// Iterative shifter/rotator: moves up to STEP bit positions per clock, start/busy/done handshake.
// Optional carry output of the last bit shifted out is enabled by defining SHIFT_CARRY_EN.
module shift_unit_iter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input logic              clk,
    input logic              rst,
    shift_unit_iter_if.slave bus
);
    localparam int unsigned AW = $clog2(WIDTH);
    localparam logic [AW-1:0] StepAmt = AW'(STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d, work_nx;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [2:0]         op_q, op_d;
    logic [AW-1:0]      rem_q, rem_d, s;
    logic [2*WIDTH-1:0] dbl, rol_t, ror_t;
`ifdef SHIFT_CARRY_EN
    logic               carry_q, carry_d, carry_nx;
    logic [AW-1:0]      lsl_idx, rsh_idx;
`endif

    // One iteration of the datapath: shift work_q by s = min(STEP, rem).
    always_comb begin
        s     = (rem_q > StepAmt) ? StepAmt : rem_q;
        dbl   = {work_q, work_q};
        rol_t = dbl << s;
        ror_t = dbl >> s;
        case (op_q)
            3'b000:  work_nx = work_q << s;
            3'b001:  work_nx = work_q >> s;
            3'b010:  work_nx = $signed(work_q) >>> s;
            3'b011:  work_nx = rol_t[2*WIDTH-1:WIDTH];
            3'b100:  work_nx = ror_t[WIDTH-1:0];
            default: work_nx = work_q;
        endcase
`ifdef SHIFT_CARRY_EN
        // Modulo-2^AW arithmetic: 0 - s equals WIDTH - s for s in 1..WIDTH-1.
        lsl_idx = '0 - s;
        rsh_idx = s - AW'(1);
        case (op_q)
            3'b000, 3'b011:         carry_nx = work_q[lsl_idx];
            3'b001, 3'b010, 3'b100: carry_nx = work_q[rsh_idx];
            default:                carry_nx = 1'b0;
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        rem_d   = rem_q;
        out_d   = out_q;
`ifdef SHIFT_CARRY_EN
        carry_d = carry_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    work_d = bus.in;
                    op_d   = bus.op;
                    rem_d  = bus.amt;
                    if (bus.amt == '0 || bus.op > 3'b100) begin
                        state_d = StDone;
                        out_d   = bus.in;
`ifdef SHIFT_CARRY_EN
                        carry_d = 1'b0;
`endif
                    end else begin
                        state_d = StShift;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                work_d = work_nx;
                rem_d  = rem_q - s;
                if (rem_q <= StepAmt) begin
                    state_d = StDone;
                    out_d   = work_nx;
`ifdef SHIFT_CARRY_EN
                    carry_d = carry_nx;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            work_q  <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            out_q   <= '0;
`ifdef SHIFT_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
`ifdef SHIFT_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign bus.busy = (state_q == StShift);
    assign bus.done = (state_q == StDone);
    assign bus.out  = out_q;
`ifdef SHIFT_CARRY_EN
    assign bus.carry = carry_q;
`endif
endmodule

// File: tb/tb_shift_unit_iter.sv
// Bench for shift_unit_iter: two instances (STEP=1 and STEP=4) checked against a
// whole-operation arithmetic model every cycle, plus directed literal expectations.
module tb_shift_unit_iter;
    localparam logic [2:0] LSL = 3'b000, LSR = 3'b001, ASR = 3'b010, ROL = 3'b011, ROR = 3'b100;

    logic clk, rst;
    int   vectors = 0, miscompares = 0;
    logic cmp_en = 1'b0;

    shift_unit_iter_if #(.WIDTH(8)) bus1 ();
    shift_unit_iter_if #(.WIDTH(8)) bus4 ();

    shift_unit_iter #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    shift_unit_iter #(.WIDTH(8), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic       start_v[2];
    logic [7:0] in_v[2];
    logic [2:0] op_v[2], amt_v[2];
    logic       busy_w[2], done_w[2];
    logic [7:0] out_w[2];

    assign bus1.start = start_v[0];
    assign bus1.in    = in_v[0];
    assign bus1.op    = op_v[0];
    assign bus1.amt   = amt_v[0];
    assign bus4.start = start_v[1];
    assign bus4.in    = in_v[1];
    assign bus4.op    = op_v[1];
    assign bus4.amt   = amt_v[1];
    assign busy_w[0]  = bus1.busy;
    assign done_w[0]  = bus1.done;
    assign out_w[0]   = bus1.out;
    assign busy_w[1]  = bus4.busy;
    assign done_w[1]  = bus4.done;
    assign out_w[1]   = bus4.out;
`ifdef SHIFT_CARRY_EN
    logic carry_w[2];
    assign carry_w[0] = bus1.carry;
    assign carry_w[1] = bus4.carry;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Whole-operation reference results computed in one go.
    function automatic logic [7:0] m_res(logic [7:0] a, logic [2:0] op, int amt);
        case (op)
            3'b000:  return a << amt;
            3'b001:  return a >> amt;
            3'b010:  return 8'($signed(a) >>> amt);
            3'b011:  return (a << amt) | (a >> (8 - amt));
            3'b100:  return (a >> amt) | (a << (8 - amt));
            default: return a;
        endcase
    endfunction

    function automatic logic m_carry(logic [7:0] a, logic [2:0] op, int amt);
        if (amt == 0) return 1'b0;
        case (op)
            3'b000, 3'b011:         return a[8 - amt];
            3'b001, 3'b010, 3'b100: return a[amt - 1];
            default:                return 1'b0;
        endcase
    endfunction

    function automatic int m_lat(logic [2:0] op, int amt, int step);
        if (amt == 0 || op > 3'b100) return 0;
        return (amt + step - 1) / step;
    endfunction

    // Timeline model: cnt = busy cycles still to run; result appears when it hits zero.
    int         cnt[2];
    logic       m_done[2], m_c[2], p_c[2];
    logic [7:0] m_out[2], p_out[2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k]    <= 0;
                m_done[k] <= 1'b0;
                m_out[k]  <= 8'h00;
                m_c[k]    <= 1'b0;
                p_out[k]  <= 8'h00;
                p_c[k]    <= 1'b0;
            end else begin
                m_done[k] <= 1'b0;
                if (cnt[k] > 0) begin
                    cnt[k] <= cnt[k] - 1;
                    if (cnt[k] == 1) begin
                        m_done[k] <= 1'b1;
                        m_out[k]  <= p_out[k];
                        m_c[k]    <= p_c[k];
                    end
                end else if (start_v[k]) begin
                    if (m_lat(op_v[k], int'(amt_v[k]), step_of(k)) == 0) begin
                        m_done[k] <= 1'b1;
                        m_out[k]  <= m_res(in_v[k], op_v[k], int'(amt_v[k]));
                        m_c[k]    <= m_carry(in_v[k], op_v[k], int'(amt_v[k]));
                    end else begin
                        cnt[k]   <= m_lat(op_v[k], int'(amt_v[k]), step_of(k));
                        p_out[k] <= m_res(in_v[k], op_v[k], int'(amt_v[k]));
                        p_c[k]   <= m_carry(in_v[k], op_v[k], int'(amt_v[k]));
                    end
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model busy dut%0d", k), 32'(busy_w[k]), 32'(cnt[k] > 0));
                chk($sformatf("model done dut%0d", k), 32'(done_w[k]), 32'(m_done[k]));
                chk($sformatf("model out dut%0d", k), 32'(out_w[k]), 32'(m_out[k]));
`ifdef SHIFT_CARRY_EN
                chk($sformatf("model carry dut%0d", k), 32'(carry_w[k]), 32'(m_c[k]));
`endif
            end
        end
    end

    // Called at a negedge; start is seen by exactly one rising edge (E0).
    task automatic issue(int k, logic [2:0] op, logic [7:0] a, logic [2:0] amt);
        start_v[k] = 1'b1;
        op_v[k]    = op;
        in_v[k]    = a;
        amt_v[k]   = amt;
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_done(int k, output int cyc);
        cyc = 0;
        while (done_w[k] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (done_w[k] !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done timeout dut%0d: waited %0d cycles, required done within 40", k, cyc);
        end
    endtask

    task automatic run(string name, int k, logic [2:0] op, logic [7:0] a, logic [2:0] amt,
                       int exp_n, logic [7:0] exp_out, logic exp_c);
        int cyc;
        issue(k, op, a, amt);
        wait_done(k, cyc);
        chk({name, " latency"}, 32'(cyc), 32'(exp_n));
        chk({name, " out"}, 32'(out_w[k]), 32'(exp_out));
`ifdef SHIFT_CARRY_EN
        chk({name, " carry"}, 32'(carry_w[k]), 32'(exp_c));
`else
        if (exp_c === 1'bx) $display("unexpected x carry in %s", name);
`endif
    endtask

    typedef struct {logic [2:0] op; logic [7:0] a; logic [2:0] amt;} vec_t;
    vec_t extra[5] = '{'{LSR, 8'hB3, 3'd7}, '{ASR, 8'h81, 3'd5}, '{ROL, 8'h3C, 3'd3},
                       '{ROR, 8'h01, 3'd1}, '{LSL, 8'hFF, 3'd4}};

    initial begin
        int cyc;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0;
            in_v[k]    = 8'h00;
            op_v[k]    = 3'b000;
            amt_v[k]   = 3'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset busy dut%0d", k), 32'(busy_w[k]), 32'd0);
            chk($sformatf("reset done dut%0d", k), 32'(done_w[k]), 32'd0);
            chk($sformatf("reset out dut%0d", k), 32'(out_w[k]), 32'h00);
        end
        rst = 1'b0;
        @(negedge clk);

        run("lsl3 step1", 0, LSL, 8'b1001_0110, 3'd3, 3, 8'b1011_0000, 1'b0);
        run("asr2 step1", 0, ASR, 8'b1001_0110, 3'd2, 2, 8'b1110_0101, 1'b1);
        run("ror4 step4", 1, ROR, 8'hA5, 3'd4, 1, 8'h5A, 1'b0);
        run("rol7 step4", 1, ROL, 8'h81, 3'd7, 2, 8'hC0, 1'b0);
        run("amt0 step1", 0, LSL, 8'h3C, 3'd0, 0, 8'h3C, 1'b0);
        run("amt0 step4", 1, LSL, 8'h3C, 3'd0, 0, 8'h3C, 1'b0);
        run("pass step1", 0, 3'b110, 8'hF0, 3'd5, 0, 8'hF0, 1'b0);

        // Asynchronous reset in the middle of a long shift.
        issue(0, LSL, 8'hFF, 3'd7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy_w[0]), 32'd0);
        chk("async rst done", 32'(done_w[0]), 32'd0);
        chk("async rst out", 32'(out_w[0]), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("lsr1 after rst", 0, LSR, 8'h80, 3'd1, 1, 8'h40, 1'b0);

        // start during SHIFT must be ignored.
        issue(0, LSL, 8'b1001_0110, 3'd3);
        start_v[0] = 1'b1;
        in_v[0]    = 8'hFF;
        op_v[0]    = LSR;
        amt_v[0]   = 3'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, cyc);
        chk("ignored start out", 32'(out_w[0]), 32'hB0);

        // start held in DONE is taken with no idle cycle.
        start_v[0] = 1'b1;
        in_v[0]    = 8'hFF;
        op_v[0]    = LSR;
        amt_v[0]   = 3'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("b2b busy", 32'(busy_w[0]), 32'd1);
        wait_done(0, cyc);
        chk("b2b latency", 32'(cyc), 32'd1);
        chk("b2b out", 32'(out_w[0]), 32'h7F);

        foreach (extra[i]) begin
            for (int k = 0; k < 2; k++) begin
                issue(k, extra[i].op, extra[i].a, extra[i].amt);
                wait_done(k, cyc);
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
